alu_issue_ctrl: RTL

- Issue controller that sits on the producer side of the 32-bit combinational ALU datapath.
- Accepts decoded ALU requests (function code, two register operands, 16-bit immediate) over a valid/ready handshake.
- Forms the ALU operands, drives the ALU's A/B/sel inputs from registers, and captures the ALU result into a held result register for writeback over a second valid/ready handshake.
- Sits between the instruction decode stage and register-file writeback.

---
 rtl/alu_issue_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller feeding a 32-bit combinational ALU: forms operands, registers the ALU inputs,
// captures the result for a valid/ready writeback. Define ALU_ISSUE_FLAGS_EN to add zero/neg/ovf flags.
module alu_issue_ctrl #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_func,
  input  logic             in_use_imm,
  input  logic [W-1:0]     in_rs,
  input  logic [W-1:0]     in_rt,
  input  logic [15:0]      in_imm,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [3:0]       alu_sel,
  input  logic [W-1:0]     alu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic [CNT_W-1:0] op_count
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     alu_a_q, alu_a_d;
  logic [W-1:0]     alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_res_q, out_res_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             accept;
`ifdef ALU_ISSUE_FLAGS_EN
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
`endif

  function automatic logic [W-1:0] form_b(input logic [3:0] func, input logic use_imm,
                                          input logic [W-1:0] rt, input logic [15:0] imm);
    if (!use_imm) return rt;
    case (func)
      4'd4, 4'd5, 4'd6, 4'd8, 4'd9: return {16'b0, imm};
      4'd10, 4'd11, 4'd12:          return {27'b0, imm[4:0]};
      default:                      return {{16{imm[15]}}, imm};
    endcase
  endfunction

  // Signed overflow only has meaning for add/sub; judged from operand and result sign bits.
  function automatic logic ovf_of(input logic [3:0] sel, input logic signed [W-1:0] a,
                                  input logic signed [W-1:0] b, input logic signed [W-1:0] r);
    case (sel)
      4'd0:    return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      4'd1:    return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      default: return 1'b0;
    endcase
  endfunction

  // A new request may slip in during the very cycle the held result drains.
  assign in_ready = rstn && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    op_count_d  = op_count_q;
`ifdef ALU_ISSUE_FLAGS_EN
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_a_d   = in_rs;
          alu_b_d   = form_b(in_func, in_use_imm, in_rt, in_imm);
          alu_sel_d = in_func;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        out_res_d   = alu_res;
        out_valid_d = 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
        zero_d      = (alu_res == '0);
        neg_d       = alu_res[W-1];
        ovf_d       = ovf_of(alu_sel_q, alu_a_q, alu_b_q, alu_res);
`endif
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          op_count_d  = op_count_q + 1'b1;
          out_valid_d = 1'b0;
          if (accept) begin
            alu_a_d   = in_rs;
            alu_b_d   = form_b(in_func, in_use_imm, in_rt, in_imm);
            alu_sel_d = in_func;
            state_d   = EXEC;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      op_count_q  <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      op_count_q  <= op_count_d;
`ifdef ALU_ISSUE_FLAGS_EN
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign op_count  = op_count_q;
`ifdef ALU_ISSUE_FLAGS_EN
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;
  assign out_ovf   = ovf_q;
`endif

endmodule
